// File: rtl/repeated_id_summer.sv
// Streaming summer of repeated-block IDs over BCD ranges, one inclusion-exclusion term per pass.
// Optional REPEATED_ID_COUNT_EN adds count_o, the number of matching IDs per batch.
module repeated_id_summer #(
    parameter int MAX_DIGITS = 10,
    parameter int BIN_W      = 4 * MAX_DIGITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*MAX_DIGITS-1:0] in_start,
    input  logic [4*MAX_DIGITS-1:0] in_end,
    input  logic                    in_last,
    input  logic                    in_mode,
    output logic [63:0]             sum_o,
    output logic                    done_o
`ifdef REPEATED_ID_COUNT_EN
    ,
    output logic [63:0]             count_o
`endif
);
    localparam int PW = 2 * BIN_W;
    localparam int DW = 4 * MAX_DIGITS;

    typedef enum logic [3:0] {
        IDLE, CONV, LEN, BOUND, CHECK, MUL, ACC, NEXTL, DONE
    } state_t;

    function automatic logic [BIN_W-1:0] pow10c(input int n);
        logic [BIN_W-1:0] r;
        r = BIN_W'(1);
        for (int i = 0; i < n; i++) r = r * BIN_W'(10);
        return r;
    endfunction

    // R = sum of 10^(i*p) for i*p < l, i.e. (10^l-1)/(10^p-1)
    function automatic logic [BIN_W-1:0] rep_c(input int l, input int p);
        logic [BIN_W-1:0] r;
        r = '0;
        if (p == 0 || l == 0 || (l % p) != 0) return r;
        for (int i = 0; i < l; i += p) r = r + pow10c(i);
        return r;
    endfunction

    function automatic logic [BIN_W-1:0] bcd2bin(input logic [DW-1:0] b);
        logic [BIN_W-1:0] r;
        r = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--)
            r = r * BIN_W'(10) + BIN_W'(b[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [BIN_W-1:0] top_bin(input logic [DW-1:0] b,
                                                 input logic [3:0] l,
                                                 input logic [3:0] p);
        logic [DW-1:0] sh;
        sh = b >> {l - p, 2'b00};
        for (int i = 0; i < MAX_DIGITS; i++)
            if (i >= int'(p)) sh[4*i +: 4] = 4'd0;
        return bcd2bin(sh);
    endfunction

    function automatic logic [3:0] p_of(input logic [3:0] l, input logic [3:0] k);
        logic [3:0] r;
        r = 4'd0;
        for (int q = 1; q <= MAX_DIGITS; q++)
            if (q * int'(k) == int'(l)) r = 4'(q);
        return r;
    endfunction

    function automatic logic term_ok(input logic [3:0] l, input logic [3:0] k,
                                     input logic mode);
        logic sqf;
        case (k)
            4'd4, 4'd8, 4'd9, 4'd12: sqf = 1'b0;
            default:                 sqf = 1'b1;
        endcase
        if (k < 4'd2) return 1'b0;
        if (!mode) return (k == 4'd2) && (l != 4'd0) && !l[0];
        return (p_of(l, k) != 4'd0) && sqf;
    endfunction

    function automatic logic [3:0] next_k(input logic [3:0] l, input logic [3:0] from,
                                          input logic mode);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 2; k <= MAX_DIGITS; k++)
            if (r == 4'd0 && k >= int'(from) && term_ok(l, 4'(k), mode)) r = 4'(k);
        return r;
    endfunction

    logic [BIN_W-1:0] pow_tab [16];
    logic [BIN_W-1:0] rep_tab [16][16];

    for (genvar gl = 0; gl < 16; gl++) begin : g_l
        assign pow_tab[gl] = pow10c(gl);
        for (genvar gp = 0; gp < 16; gp++) begin : g_p
            assign rep_tab[gl][gp] = rep_c(gl, gp);
        end
    end

    state_t state, state_n;

    logic [DW-1:0]       s_bcd, e_bcd;
    logic                last_r, mode_r, in_batch, neg_r, done_r;
    logic [BIN_W-1:0]    s_bin, e_bin, lo_r, hi_r, blo_r, bhi_r, rep_r, half_r;
    logic [3:0]          lvl, le, k_r;
    logic signed [65:0]  acc;
`ifdef REPEATED_ID_COUNT_EN
    logic [BIN_W-1:0]    n_r;
    logic signed [65:0]  cnt;
`endif

    logic [BIN_W-1:0]    s_conv, e_conv, lo_min, hi_max, lo_c, hi_c, blo_c, bhi_c;
    logic [3:0]          ls_c, le_c, p_c, k_from, k_nxt, l_nxt;
    logic                s_under, e_over;
    logic [PW-1:0]       lo_prod, hi_prod, term;

    assign in_ready = rst && (state == IDLE);
    assign sum_o    = 64'(acc);
    assign done_o   = done_r;
`ifdef REPEATED_ID_COUNT_EN
    assign count_o  = 64'(cnt);
`endif

    always_comb begin
        s_conv = bcd2bin(s_bcd);
        e_conv = bcd2bin(e_bcd);
        ls_c   = 4'd1;
        le_c   = 4'd1;
        for (int i = 1; i < MAX_DIGITS; i++) begin
            if (s_conv >= pow_tab[i]) ls_c = ls_c + 4'd1;
            if (e_conv >= pow_tab[i]) le_c = le_c + 4'd1;
        end
        p_c     = p_of(lvl, k_r);
        lo_min  = pow_tab[lvl - 4'd1];
        hi_max  = pow_tab[lvl] - BIN_W'(1);
        s_under = s_bin < lo_min;
        e_over  = e_bin > hi_max;
        lo_c    = s_under ? lo_min : s_bin;
        hi_c    = e_over ? hi_max : e_bin;
        blo_c   = s_under ? pow_tab[p_c - 4'd1] : top_bin(s_bcd, lvl, p_c);
        bhi_c   = e_over ? pow_tab[p_c] - BIN_W'(1) : top_bin(e_bcd, lvl, p_c);
        lo_prod = PW'(blo_r) * PW'(rep_r);
        hi_prod = PW'(bhi_r) * PW'(rep_r);
        term    = PW'(rep_r) * PW'(half_r);
        k_from  = (state == LEN) ? 4'd2 : k_r + 4'd1;
        k_nxt   = next_k(lvl, k_from, mode_r);
        l_nxt   = lvl + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (in_valid && in_ready) state_n = CONV;
            CONV:  state_n = LEN;
            LEN:   state_n = (k_nxt == 4'd0) ? NEXTL : BOUND;
            BOUND: state_n = CHECK;
            CHECK: state_n = MUL;
            MUL:   state_n = ACC;
            ACC:   state_n = (k_nxt == 4'd0) ? NEXTL : BOUND;
            NEXTL: begin
                if (l_nxt > le) state_n = last_r ? DONE : IDLE;
                else            state_n = LEN;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_bcd    <= '0;
            e_bcd    <= '0;
            last_r   <= 1'b0;
            mode_r   <= 1'b0;
            in_batch <= 1'b0;
            neg_r    <= 1'b0;
            done_r   <= 1'b0;
            s_bin    <= '0;
            e_bin    <= '0;
            lo_r     <= '0;
            hi_r     <= '0;
            blo_r    <= '0;
            bhi_r    <= '0;
            rep_r    <= '0;
            half_r   <= '0;
            lvl      <= '0;
            le       <= '0;
            k_r      <= '0;
            acc      <= '0;
`ifdef REPEATED_ID_COUNT_EN
            n_r      <= '0;
            cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    s_bcd    <= in_start;
                    e_bcd    <= in_end;
                    last_r   <= in_last;
                    in_batch <= 1'b1;
                    // first beat of a batch opens a fresh sum
                    if (!in_batch) begin
                        acc    <= '0;
                        done_r <= 1'b0;
                        mode_r <= in_mode;
`ifdef REPEATED_ID_COUNT_EN
                        cnt    <= '0;
`endif
                    end
                end
                CONV: begin
                    s_bin <= s_conv;
                    e_bin <= e_conv;
                    lvl   <= ls_c;
                    le    <= le_c;
                end
                LEN: k_r <= k_nxt;
                BOUND: begin
                    lo_r  <= lo_c;
                    hi_r  <= hi_c;
                    blo_r <= blo_c;
                    bhi_r <= bhi_c;
                    rep_r <= rep_tab[lvl][p_c];
                    neg_r <= (k_r == 4'd6) || (k_r == 4'd10);
                end
                CHECK: begin
                    blo_r <= blo_r + BIN_W'(lo_prod < PW'(lo_r));
                    bhi_r <= bhi_r - BIN_W'(hi_prod > PW'(hi_r));
                end
                MUL: begin
                    // (b_lo+b_hi)*(n) is always even, so halve before scaling by R
                    if (blo_r <= bhi_r)
                        half_r <= BIN_W'((PW'(blo_r + bhi_r) *
                                  PW'(bhi_r - blo_r + BIN_W'(1))) >> 1);
                    else
                        half_r <= '0;
`ifdef REPEATED_ID_COUNT_EN
                    n_r <= (blo_r <= bhi_r) ? bhi_r - blo_r + BIN_W'(1) : '0;
`endif
                end
                ACC: begin
                    acc <= neg_r ? acc - $signed(66'(term)) : acc + $signed(66'(term));
`ifdef REPEATED_ID_COUNT_EN
                    cnt <= neg_r ? cnt - $signed(66'(n_r)) : cnt + $signed(66'(n_r));
`endif
                    k_r <= k_nxt;
                end
                NEXTL: lvl <= l_nxt;
                DONE: begin
                    done_r   <= 1'b1;
                    in_batch <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
